// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: SAR conversion sequencer.
// Runs acquisition, then a bit-serial successive-approximation search
// driven by the comparator's Inc/Dcr flags, then either holds or tracks
// the input in single-LSB steps. It returns the code with a one-cycle Done strobe.
module sar_conv_sequencer #(
  parameter int unsigned DATA   = 8,
  parameter int unsigned ACQ    = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                      ClockT,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic                      Track,
  input  logic                      Inc,
  input  logic                      Dcr,
  output logic [1:0]                StateP,
  output logic [DATA-1:0]           SAROut,
  output logic [DATA-1:0]           Result,
  output logic                      Done,
  output logic                      Busy,
  output logic [$clog2(DATA)-1:0]   BitIdx
);

  localparam int unsigned IW   = $clog2(DATA);
  localparam int unsigned CMAX = (ACQ > SETTLE) ? ACQ : SETTLE;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]   ACQ_LAST = CW'(ACQ - 1);
  localparam logic [CW-1:0]   SET_LAST = CW'(SETTLE - 1);
  localparam logic [DATA-1:0] MIDSCALE = {1'b1, {(DATA-1){1'b0}}};
  localparam logic [IW-1:0]   MSB_IDX  = IW'(DATA - 1);

  // Encodings match the StateP values the datapath expects
  typedef enum logic [1:0] {
    ST_TRACK  = 2'b00,
    ST_SEARCH = 2'b01,
    ST_HOLD   = 2'b10,
    ST_ACQ    = 2'b11
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DATA-1:0] sar_q;
  logic [DATA-1:0] res_q;
  logic            done_q;
  logic [IW-1:0]   bit_q;

  logic [DATA-1:0] dec_d;
  logic [DATA-1:0] trial_d;
  logic [DATA-1:0] trk_d;

  // Bit decision, next trial code and saturating tracking step
  always_comb begin
    dec_d = sar_q;
    if (Dcr && !Inc) begin
      dec_d[bit_q] = 1'b0;
    end
    trial_d = dec_d;
    if (bit_q != '0) begin
      trial_d[bit_q - IW'(1)] = 1'b1;
    end
    trk_d = sar_q;
    if (Inc && !Dcr && (sar_q != '1)) begin
      trk_d = sar_q + DATA'(1);
    end else if (Dcr && !Inc && (sar_q != '0)) begin
      trk_d = sar_q - DATA'(1);
    end
  end

  // Sequencer FSM with registered outputs; Abort overrides every state
  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      sar_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (Abort) begin
        state_q <= ST_HOLD;
        cnt_q   <= '0;
        bit_q   <= '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (Start) begin
              state_q <= ST_ACQ;
              cnt_q   <= '0;
              sar_q   <= MIDSCALE;
            end
          end
          ST_ACQ: begin
            if (cnt_q == ACQ_LAST) begin
              state_q <= ST_SEARCH;
              cnt_q   <= '0;
              bit_q   <= MSB_IDX;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_SEARCH: begin
            if (cnt_q == SET_LAST) begin
              cnt_q <= '0;
              if (bit_q != '0) begin
                sar_q <= trial_d;
                bit_q <= bit_q - IW'(1);
              end else begin
                sar_q   <= dec_d;
                res_q   <= dec_d;
                done_q  <= 1'b1;
                state_q <= Track ? ST_TRACK : ST_HOLD;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_TRACK: begin
            if (Start) begin
              state_q <= ST_ACQ;
              cnt_q   <= '0;
              sar_q   <= MIDSCALE;
            end else if (!Track) begin
              state_q <= ST_HOLD;
            end else begin
              sar_q <= trk_d;
              res_q <= trk_d;
            end
          end
          default: state_q <= ST_HOLD;
        endcase
      end
    end
  end

  assign StateP = state_q;
  assign SAROut = sar_q;
  assign Result = res_q;
  assign Done   = done_q;
  assign BitIdx = bit_q;
  assign Busy   = (state_q == ST_ACQ) || (state_q == ST_SEARCH);

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Scoreboard bench for sar_conv_sequencer: a comparator model closes the
// loop around SAROut, a reference SAR search predicts results and trial
// codes, and a monitor checks every Done strobe against queued expectations.
module tb_sar_conv_sequencer;

  localparam int DATA   = 8;
  localparam int ACQ    = 4;
  localparam int SETTLE = 2;
  localparam int CONV   = ACQ + DATA * SETTLE;

  logic             ClockT = 1'b0;
  logic             Reset  = 1'b1;
  logic             Start  = 1'b0;
  logic             Abort  = 1'b0;
  logic             Track  = 1'b0;
  logic             Inc, Dcr;
  logic [1:0]       StateP;
  logic [DATA-1:0]  SAROut, Result;
  logic             Done, Busy;
  logic [2:0]       BitIdx;

  int tgt = 0;
  int mode = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int last_result = 0;
  int texp = 0;
  int exp_trials[DATA];

  typedef struct {
    int res;
    int at;
  } exp_t;
  exp_t sbq[$];

  sar_conv_sequencer #(.DATA(DATA), .ACQ(ACQ), .SETTLE(SETTLE)) dut (
    .ClockT(ClockT), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Track(Track), .Inc(Inc), .Dcr(Dcr), .StateP(StateP),
    .SAROut(SAROut), .Result(Result), .Done(Done), .Busy(Busy),
    .BitIdx(BitIdx)
  );

  always #5 ClockT = ~ClockT;
  always @(posedge ClockT) cyc <= cyc + 1;

  // Comparator behaviour: mode 0 ideal vs target, 1 both flags,
  // 2 Inc only, 3 Dcr only, 4 neither. Returns {inc, dcr}.
  function automatic logic [1:0] cmp_model(input int code, input int t, input int m);
    case (m)
      0:       return {code < t, code > t};
      1:       return 2'b11;
      2:       return 2'b10;
      3:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  assign {Inc, Dcr} = cmp_model(int'(SAROut), tgt, mode);

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference binary search: each bit tried high, dropped only on Dcr-alone
  task automatic sar_ref(input int t, input int m, output int res);
    int code;
    int trial;
    logic [1:0] f;
    code = 0;
    for (int k = DATA - 1; k >= 0; k--) begin
      trial = code | (1 << k);
      exp_trials[DATA-1-k] = trial;
      f = cmp_model(trial, t, m);
      code = (f == 2'b01) ? code : trial;
    end
    res = code;
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 100000) begin
      @(negedge ClockT);
      guard++;
    end
  endtask

  // Monitor: every Done must match the oldest queued expectation
  always @(negedge ClockT) begin
    exp_t e;
    if (!Reset && Done) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 Result=%0h expected no Done", Result);
      end else begin
        e = sbq.pop_front();
        check("done_result", int'(Result), e.res);
        check("done_cycle", cyc, e.at);
        check("busy_at_done", int'(Busy), 0);
      end
    end
  end

  // One conversion from HOLD; trial codes checked at both cycles of each bit
  task automatic convert(input int t, input int m, input bit trk);
    int e0;
    int res;
    tgt = t;
    mode = m;
    Track = trk;
    sar_ref(t, m, res);
    Start = 1'b1;
    e0 = cyc + 1;
    sbq.push_back('{res: res, at: e0 + CONV});
    last_result = res;
    @(negedge ClockT);
    Start = 1'b0;
    check("acq_state", int'(StateP), 3);
    check("acq_busy", int'(Busy), 1);
    for (int j = 0; j < DATA; j++) begin
      for (int s = 0; s < SETTLE; s++) begin
        wait_cyc(e0 + ACQ + j * SETTLE + s);
        check("trial_code", int'(SAROut), exp_trials[j]);
        check("bit_idx", int'(BitIdx), DATA - 1 - j);
        check("search_state", int'(StateP), 1);
      end
    end
    wait_cyc(e0 + CONV + 1);
    check("post_state", int'(StateP), trk ? 0 : 2);
    check("post_bitidx", int'(BitIdx), 0);
  endtask

  // Tracking steps: expected code moves by one LSB with saturation
  task automatic track_steps(input int n, input int m, input int t);
    logic [1:0] f;
    for (int i = 0; i < n; i++) begin
      tgt = t;
      mode = m;
      f = cmp_model(texp, t, m);
      @(negedge ClockT);
      if (f == 2'b10) texp = (texp < 255) ? texp + 1 : 255;
      else if (f == 2'b01) texp = (texp > 0) ? texp - 1 : 0;
      check("track_code", int'(SAROut), texp);
      check("track_result", int'(Result), texp);
      check("track_state", int'(StateP), 0);
    end
  endtask

  task automatic abort_test;
    int guard;
    int sv;
    tgt = int'($urandom_range(0, 255));
    mode = 0;
    Track = 1'b0;
    Start = 1'b1;
    @(negedge ClockT);
    Start = 1'b0;
    guard = 0;
    while (!(StateP == 2'b01 && BitIdx == 3'd4) && guard < 100) begin
      @(negedge ClockT);
      guard++;
    end
    check("abort_reach_bit4", int'(guard < 100), 1);
    sv = int'(SAROut);
    Abort = 1'b1;
    @(negedge ClockT);
    Abort = 1'b0;
    check("abort_state", int'(StateP), 2);
    check("abort_busy", int'(Busy), 0);
    check("abort_result", int'(Result), last_result);
    check("abort_sarout", int'(SAROut), sv);
    check("abort_done", int'(Done), 0);
    check("abort_bitidx", int'(BitIdx), 0);
    repeat (3) @(negedge ClockT);
    check("abort_stays_hold", int'(StateP), 2);
  endtask

  task automatic reset_test;
    tgt = int'($urandom_range(0, 255));
    mode = 0;
    Track = 1'b0;
    Start = 1'b1;
    @(negedge ClockT);
    Start = 1'b0;
    repeat (ACQ + 3) @(negedge ClockT);
    check("rst_pre_search", int'(StateP), 1);
    #2 Reset = 1'b1;
    #1;
    check("rst_async_sarout", int'(SAROut), 0);
    check("rst_async_state", int'(StateP), 2);
    check("rst_async_busy", int'(Busy), 0);
    check("rst_async_result", int'(Result), 0);
    check("rst_async_bitidx", int'(BitIdx), 0);
    @(negedge ClockT);
    Reset = 1'b0;
    last_result = 0;
    @(negedge ClockT);
    check("rst_release_hold", int'(StateP), 2);
  endtask

  task automatic b2b_test;
    int e0;
    mode = 1;
    tgt = 0;
    Track = 1'b0;
    Start = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 3; i++) sbq.push_back('{res: 255, at: e0 + CONV + i * (CONV + 1)});
    last_result = 255;
    wait_cyc(e0 + CONV);
    check("b2b_hold_gap", int'(StateP), 2);
    wait_cyc(e0 + CONV + 1);
    check("b2b_restart", int'(StateP), 3);
    wait_cyc(e0 + 3 * CONV + 2);
    Start = 1'b0;
    @(negedge ClockT);
    check("b2b_final_hold", int'(StateP), 2);
  endtask

  initial begin
    repeat (2) @(negedge ClockT);
    check("reset_statep", int'(StateP), 2);
    check("reset_sarout", int'(SAROut), 0);
    check("reset_result", int'(Result), 0);
    check("reset_done", int'(Done), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_bitidx", int'(BitIdx), 0);
    Reset = 1'b0;
    @(negedge ClockT);

    convert(8'h5A, 0, 1'b0);
    convert(8'h00, 0, 1'b0);
    convert(8'hFF, 0, 1'b0);
    repeat (20) convert(int'($urandom_range(0, 255)), 0, 1'b0);
    convert(8'h3C, 4, 1'b0);
    convert(8'h3C, 3, 1'b0);
    convert(8'h3C, 2, 1'b0);
    convert(8'h3C, 1, 1'b0);

    abort_test();
    reset_test();
    convert(8'hA7, 0, 1'b0);

    convert(8'hFE, 0, 1'b1);
    texp = 8'hFE;
    track_steps(6, 0, 256);
    track_steps(260, 3, 0);
    for (int i = 0; i < 40; i++)
      track_steps(1, int'($urandom_range(0, 4)), int'($urandom_range(0, 256)));
    mode = 4;
    Track = 1'b0;
    @(negedge ClockT);
    check("track_exit_state", int'(StateP), 2);
    check("track_exit_sarout", int'(SAROut), texp);

    b2b_test();

    repeat (5) @(negedge ClockT);
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/sar_conv_sequencer.md
# sar_conv_sequencer

Sequencer for the SAR converter datapath. On a start request it runs acquisition, then a bit-serial successive-approximation search driven by the comparator's Inc/Dcr flags, and optionally stays in single-LSB tracking. It drives StateP and SAROut into the SAR timer/output stage and returns the converted code with a one-cycle Done strobe.

## Interface

Parameters:
- DATA, 8: SAR code width (≥2).
- ACQ, 4: acquisition length in cycles (≥1).
- SETTLE, 2: cycles per bit decision (≥1). The comparator is sampled on the last cycle of each bit.

Ports:
- ClockT, in, 1: sole clock; all state updates on its rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: conversion request; level-sampled.
- Abort, in, 1: cancel; has priority over Start.
- Track, in, 1: after Done, enter tracking instead of hold.
- Inc, in, 1: comparator flag, DAC below input.
- Dcr, in, 1: comparator flag, DAC above input.
- StateP, out, 2: phase to datapath. 2'b11 ACQUIRE, 2'b01 SEARCH, 2'b10 HOLD, 2'b00 TRACK.
- SAROut, out, DATA: current trial/tracked code.
- Result, out, DATA: last completed conversion code.
- Done, out, 1: one-cycle strobe; Result is valid in the same cycle.
- Busy, out, 1: high in ACQUIRE and SEARCH.
- BitIdx, out, log2(DATA) bits (min 1): bit under test in SEARCH; 0 otherwise.

## Operation

- Reset values: StateP=2'b10, SAROut=0, Result=0, Done=0, Busy=0, BitIdx=0. Internal cycle counter = 0.
- HOLD: SAROut holds. Start=1 and Abort=0 → ACQUIRE, counter=0, SAROut={1'b1,{DATA-1{0}}}.
- ACQUIRE: lasts ACQ cycles, SAROut held at midscale. On the last cycle → SEARCH, BitIdx=DATA-1, counter=0.
- SEARCH: each bit k occupies SETTLE cycles. On its last cycle:
  - Dcr=1 and Inc=0: clear bit k. Any other combination, including both set or both clear: keep bit k.
  - If k>0: set bit k-1, BitIdx=k-1.
  - If k=0: Result ← final code, Done=1 next cycle, then → TRACK if Track=1, else → HOLD.
- TRACK:
  - Inc=1, Dcr=0: SAROut+1, saturating at all-ones.
  - Dcr=1, Inc=0: SAROut-1, saturating at 0.
  - Otherwise hold. Result follows SAROut each cycle; Done stays 0.
  - Track=0 → HOLD. Start=1 → ACQUIRE (restart).
- Abort=1 in any state → HOLD next cycle. SAROut and Result keep their values, no Done, Busy=0.
- Start held high continuously: a new conversion starts on the first HOLD cycle after Done (back-to-back).
- Start while Busy: ignored.
- Arithmetic: all DATA bits unsigned. No wrap in TRACK. The counter is wide enough for max(ACQ, SETTLE).

## Timing

- Registered outputs only; no combinational input-to-output paths.
- Edge E0 samples Start in HOLD. StateP=11 from E0 through E0+ACQ; the SEARCH phase spans DATA×SETTLE cycles.
- Done is high for exactly the one cycle after edge E0+ACQ+DATA×SETTLE. Defaults: 4+16 = 20 cycles after Start sampling.
- Busy deasserts in the same cycle Done asserts.
- SAROut changes only at bit boundaries. The datapath therefore sees each trial code stable for SETTLE cycles.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). After Reset falls, the first rising edge evaluates from HOLD.

## Test plan

- Comparator model Inc=(SAROut<0x5A), Dcr=(SAROut>0x5A); Start pulse, Track=0 → SAROut trial sequence 80,40,60,50,58,5C,5A,5B. Result=0x5A with Done at cycle 21, StateP returns to 10.
- Targets 0x00 and 0xFF → Result 0x00 and 0xFF respectively. Both finish at cycle 21 with no overflow.
- Track=1, target 0xFE, then model target raised to 0xFF+: SAROut steps to FF and saturates; Inc held 5 more cycles leaves FF. Then Dcr forced at SAROut=0 → stays 0.
- Abort asserted at BitIdx=4 → StateP=10 next cycle, Busy=0, no Done, Result unchanged from prior value.
- Reset pulsed during SEARCH (between edges) → immediately SAROut=0, StateP=10, Busy=0. A subsequent Start converts correctly.
- Inc=Dcr=1 on every decision → all bits kept, Result=0xFF. Start held high → back-to-back conversions with a single HOLD cycle between them.
